lsu_ctrl: RTL

- Load/store unit directly downstream of the main decoder.
- Takes the decoded memory request (MemWrite, load select, access length, address, store data) and runs a multi-cycle req/gnt/rvalid handshake to data memory.
- Generates byte enables and lane-replicated store data, and extracts and sign/zero-extends load data.
- Stalls the core while an access is in flight.

---
 rtl/lsu_ctrl.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between the main decoder and data memory.
// Runs a req/gnt/rvalid handshake, builds byte enables and lane-replicated
// store data, sign/zero-extends load data and stalls the core while busy.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses trap with err instead of reaching memory.
module lsu_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_len,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        st_done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Byte enables for the access size at byte offset off.
    function automatic logic [3:0] calc_be(input logic [1:0] len, input logic [1:0] off);
        logic [3:0] be;
        case (len)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data across all lanes it may land in.
    function automatic logic [31:0] calc_wdata(input logic [1:0] len, input logic [31:0] wdata);
        logic [31:0] wd;
        case (len)
            2'b00:   wd = {4{wdata[7:0]}};
            2'b01:   wd = {2{wdata[15:0]}};
            default: wd = wdata;
        endcase
        return wd;
    endfunction

    // Pick the addressed lane out of the read word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [1:0] len, input logic [1:0] off,
                                                input logic uns, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'b00:   b = rdata[7:0];
            2'b01:   b = rdata[15:8];
            2'b10:   b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (len)
            2'b00:   res = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   res = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    // Half needs addr[0]=0, word needs addr[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] len, input logic [1:0] off);
        return ((len == 2'b01) && off[0]) || (len[1] && (off != 2'b00));
    endfunction
`endif

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             we_r;
    logic [1:0]       len_r;
    logic             uns_r;
    logic [1:0]       off_r;
    logic             mem_req_r;
    logic             mem_we_r;
    logic [31:0]      mem_addr_r;
    logic [3:0]       mem_be_r;
    logic [31:0]      mem_wdata_r;
    logic             ld_valid_r;
    logic             st_done_r;
    logic             err_r;
    logic [31:0]      ld_data_r;

    logic             busy_s;
    logic             misalign_s;
    logic             timeout_s;
    logic [31:0]      ext_s;

    // Stall follows req_valid in IDLE so the core stops in the request cycle.
    always_comb begin
        busy_s = 1'b0;
        case (state_r)
            IDLE:    busy_s = req_valid;
            REQ:     busy_s = 1'b1;
            WAIT:    busy_s = 1'b1;
            default: busy_s = 1'b0;
        endcase
    end

    // Misalignment trap decision on the incoming request.
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_s = is_misaligned(req_len, req_addr[1:0]);
`else
        misalign_s = 1'b0;
`endif
    end

    // Timeout flag and extended read data from the registered access fields.
    always_comb begin
        timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYC - 1));
        ext_s     = load_extend(len_r, off_r, uns_r, mem_rdata);
    end

    // Access FSM with registered memory-side signals and completion pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            we_r        <= 1'b0;
            len_r       <= 2'b00;
            uns_r       <= 1'b0;
            off_r       <= 2'b00;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'd0;
            ld_valid_r  <= 1'b0;
            st_done_r   <= 1'b0;
            err_r       <= 1'b0;
            ld_data_r   <= 32'd0;
        end else begin
            ld_valid_r <= 1'b0;
            st_done_r  <= 1'b0;
            err_r      <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        we_r  <= req_we;
                        len_r <= req_len;
                        uns_r <= req_unsigned;
                        off_r <= req_addr[1:0];
                        cnt_r <= '0;
                        if (misalign_s) begin
                            state_r   <= DONE;
                            err_r     <= 1'b1;
                            ld_data_r <= 32'd0;
                        end else begin
                            state_r     <= REQ;
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= req_we;
                            mem_addr_r  <= {req_addr[31:2], 2'b00};
                            mem_be_r    <= calc_be(req_len, req_addr[1:0]);
                            mem_wdata_r <= calc_wdata(req_len, req_wdata);
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (mem_gnt) begin
                        mem_req_r <= 1'b0;
                        if (we_r) begin
                            state_r   <= DONE;
                            st_done_r <= 1'b1;
                        end else if (mem_rvalid) begin
                            state_r    <= DONE;
                            ld_valid_r <= 1'b1;
                            ld_data_r  <= ext_s;
                        end else begin
                            state_r <= WAIT;
                        end
                    end else if (timeout_s) begin
                        mem_req_r <= 1'b0;
                        state_r   <= DONE;
                        err_r     <= 1'b1;
                        ld_data_r <= 32'd0;
                    end else begin
                        state_r <= REQ;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (mem_rvalid) begin
                        state_r    <= DONE;
                        ld_valid_r <= 1'b1;
                        ld_data_r  <= ext_s;
                    end else if (timeout_s) begin
                        state_r   <= DONE;
                        err_r     <= 1'b1;
                        ld_data_r <= 32'd0;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_s;
    assign ld_valid  = ld_valid_r;
    assign ld_data   = ld_data_r;
    assign st_done   = st_done_r;
    assign err       = err_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_be    = mem_be_r;
    assign mem_wdata = mem_wdata_r;

endmodule
